// File: rtl/hs_channel_arbiter_if.sv
// Bundle between the matrix requesters, the arbiter and the CLK1->CLK2 handshake synchronizer.
// The arbiter uses the slave view; the requester/synchronizer side uses the master view.
interface hs_channel_arbiter_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_din;
  logic [NREQ-1:0]    req_ack;
  logic [NREQ-1:0]    grant;
  logic               out_idle;
  logic               handshake_sready;
  logic [DW-1:0]      handshake_din;
  logic               burst_done;
  logic               burst_abort;

  modport slave (
    input  req, req_din, out_idle,
    output req_ack, grant, handshake_sready, handshake_din, burst_done, burst_abort
  );

  modport master (
    output req, req_din, out_idle,
    input  req_ack, grant, handshake_sready, handshake_din, burst_done, burst_abort
  );
endinterface

// File: rtl/hs_channel_arbiter.sv
// Round-robin burst arbiter sharing one CLK1->CLK2 handshake synchronizer among NREQ sources.
// The owner keeps the channel for BURST_LEN words; each word runs LOAD/WAIT_IDLE/SEND/GUARD.
module hs_channel_arbiter #(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned DW        = 8,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned GUARD     = 2   // must be >= 1
) (
  input logic                 clk,
  input logic                 rst_n,
  hs_channel_arbiter_if.slave bus
);

  localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned WCW = $clog2(BURST_LEN + 1);
  localparam int unsigned GCW = $clog2(GUARD + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StWaitIdle, StSend, StGuard} state_e;

  state_e          state_q;
  logic [NREQ-1:0] grant_q;
  logic [IW-1:0]   owner_q;
  logic [IW-1:0]   rr_ptr_q;
  logic [WCW-1:0]  word_cnt_q;
  logic [GCW-1:0]  guard_cnt_q;
  logic [DW-1:0]   din_q;
  logic            sready_q;
  logic            done_q;

  logic [IW-1:0]   pick;
  logic [IW-1:0]   next_ptr;
  logic [DW-1:0]   owner_din;
  logic            owner_req;

  // First requester at or after rr_ptr, modulo NREQ.
  always_comb begin : p_pick
    int unsigned j;
    logic        found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = int'(rr_ptr_q) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!found && bus.req[IW'(j)]) begin
        pick  = IW'(j);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    owner_din = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (owner_q == IW'(i)) owner_din = bus.req_din[i*DW +: DW];
    end
  end

  assign owner_req = |(grant_q & bus.req);
  assign next_ptr  = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      word_cnt_q  <= '0;
      guard_cnt_q <= '0;
      din_q       <= '0;
      sready_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      sready_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (|bus.req) begin
            owner_q    <= pick;
            grant_q    <= NREQ'(1) << pick;
            word_cnt_q <= '0;
            state_q    <= StLoad;
          end
        end
        StLoad: begin
          if (owner_req) begin
            din_q   <= owner_din;
            state_q <= StWaitIdle;
          end else begin
            grant_q  <= '0;
            rr_ptr_q <= next_ptr;
            din_q    <= '0;
            state_q  <= StIdle;
          end
        end
        StWaitIdle: begin
          if (bus.out_idle) begin
            sready_q <= 1'b1;
            state_q  <= StSend;
          end
        end
        StSend: begin
          word_cnt_q  <= word_cnt_q + WCW'(1);
          guard_cnt_q <= GCW'(GUARD);
          state_q     <= StGuard;
        end
        StGuard: begin
          // out_idle still reflects the previous word until the synchronizer catches up.
          if (guard_cnt_q <= GCW'(1)) begin
            if (word_cnt_q == WCW'(BURST_LEN)) begin
              done_q   <= 1'b1;
              grant_q  <= '0;
              rr_ptr_q <= next_ptr;
              din_q    <= '0;
              state_q  <= StIdle;
            end else begin
              state_q <= StLoad;
            end
          end else begin
            guard_cnt_q <= guard_cnt_q - GCW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.grant            = grant_q;
  assign bus.handshake_sready = sready_q;
  assign bus.handshake_din    = din_q;
  assign bus.burst_done       = done_q;
  assign bus.req_ack          = (state_q == StLoad) ? (grant_q & bus.req) : '0;
  assign bus.burst_abort      = (state_q == StLoad) && !owner_req;

endmodule
